// File: rtl/cpu_mem_arbiter_if.sv
// rtl/cpu_mem_arbiter_if.sv - CPU/DMA request ports and shared memory port bundle
interface cpu_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - round-robin CPU/DMA arbiter for one shared memory port
module cpu_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_mem_arbiter_if.slave      bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int         LAT      = (MEM_LAT < 1) ? 1 : ((MEM_LAT > 3) ? 3 : MEM_LAT);
    localparam logic [1:0] LAT_INIT = 2'(LAT);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic              owner_dma;
    logic              owner_dma_nxt;
    logic              last_dma;
    logic              last_dma_nxt;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dma_rdata_q;

    logic              grant_any;
    logic              grant_dma;
    logic              rd_done;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= S_IDLE;
            cnt         <= 2'd0;
            owner_dma   <= 1'b0;
            last_dma    <= 1'b1;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            owner_dma <= owner_dma_nxt;
            last_dma  <= last_dma_nxt;
            if (bus.cpu_rvalid) begin
                cpu_rdata_q <= bus.mem_rdata;
            end
            if (bus.dma_rvalid) begin
                dma_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        owner_dma_nxt = owner_dma;
        last_dma_nxt  = last_dma;
        grant_any     = 1'b0;
        grant_dma     = 1'b0;
        rd_done       = 1'b0;
        win_we        = 1'b0;
        win_addr      = '0;
        win_wdata     = '0;

        case (state)
            S_IDLE: begin
                // A reset cycle never grants, even with requests pending
                if (!rst_n && (bus.cpu_req || bus.dma_req)) begin
                    grant_any    = 1'b1;
                    grant_dma    = bus.dma_req && (!bus.cpu_req || !last_dma);
                    last_dma_nxt = grant_dma;
                    win_we       = grant_dma ? bus.dma_we    : bus.cpu_we;
                    win_addr     = grant_dma ? bus.dma_addr  : bus.cpu_addr;
                    win_wdata    = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                    if (!win_we) begin
                        state_nxt     = S_WAIT;
                        cnt_nxt       = LAT_INIT;
                        owner_dma_nxt = grant_dma;
                    end
                end
            end
            S_WAIT: begin
                // Data returns in the cycle the counter steps down to zero
                cnt_nxt = cnt - 2'd1;
                if (cnt <= 2'd1) begin
                    rd_done   = !rst_n;
                    cnt_nxt   = 2'd0;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cpu_gnt    = grant_any && !grant_dma;
    assign bus.dma_gnt    = grant_any &&  grant_dma;

    assign bus.mem_en     = grant_any;
    assign bus.mem_we     = grant_any && win_we;
    assign bus.mem_addr   = win_addr;
    assign bus.mem_wdata  = win_wdata;

    assign bus.cpu_rvalid = rd_done && !owner_dma;
    assign bus.dma_rvalid = rd_done &&  owner_dma;
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : dma_rdata_q;

    assign bus.busy       = (state == S_WAIT);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb/tb_cpu_mem_arbiter.sv - scoreboard bench for cpu_mem_arbiter
module tb_cpu_mem_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MEM_LAT = 2;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;
    } stim_t;

    typedef struct {
        int          cyc;
        bit          dma;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        bit          dma;
        logic [31:0] data;
    } rv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    bit   cpu_g = 1'b0;
    bit   dma_g = 1'b0;

    stim_t       cpu_q[$];
    stim_t       dma_q[$];
    gnt_t        exp_g[$];
    rv_t         exp_rv[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] env_mem[logic [31:0]];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cpu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_stim(input bit dma, input bit we, input logic [31:0] a,
                             input logic [31:0] d, input int dly);
        stim_t s;
        s.we = we; s.addr = a; s.wdata = d; s.dly = dly;
        if (dma) dma_q.push_back(s);
        else     cpu_q.push_back(s);
    endtask

    // Requesters: hold a request until its grant, then take the next one or go idle
    initial begin
        stim_t s;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.cpu_req && cpu_g) begin
                bus.cpu_req = 1'b0; bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
                bus.cpu_we = 1'($urandom_range(0, 1));
            end
            if (!bus.cpu_req && cpu_q.size() > 0) begin
                if (cpu_q[0].dly > 0) cpu_q[0].dly = cpu_q[0].dly - 1;
                else begin
                    s = cpu_q.pop_front();
                    bus.cpu_req = 1'b1; bus.cpu_we = s.we; bus.cpu_addr = s.addr; bus.cpu_wdata = s.wdata;
                end
            end
            if (bus.dma_req && dma_g) begin
                bus.dma_req = 1'b0; bus.dma_addr = $urandom; bus.dma_wdata = $urandom;
                bus.dma_we = 1'($urandom_range(0, 1));
            end
            if (!bus.dma_req && dma_q.size() > 0) begin
                if (dma_q[0].dly > 0) dma_q[0].dly = dma_q[0].dly - 1;
                else begin
                    s = dma_q.pop_front();
                    bus.dma_req = 1'b1; bus.dma_we = s.we; bus.dma_addr = s.addr; bus.dma_wdata = s.wdata;
                end
            end
        end
    end

    // Memory: writes land at once, read data appears MEM_LAT cycles after the strobe
    int          rd_due = -1;
    logic [31:0] rd_data = '0;
    initial begin
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_rdata = (cyc == rd_due) ? rd_data : $urandom;
        end
    end
    initial forever begin
        @(negedge clk);
        if (bus.mem_en === 1'b1) begin
            if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
            else begin
                rd_due  = cyc + MEM_LAT;
                rd_data = env_mem.exists(bus.mem_addr) ? env_mem[bus.mem_addr] : dflt(bus.mem_addr);
            end
        end
    end

    // Reference model: memory port is free from cycle free_at; ties go to whoever did not win last
    int          free_at = 0;
    int          b_lo = 1;
    int          b_hi = 0;
    bit          m_last_dma = 1'b1;
    bit          prev_rst = 1'b0;
    bit          exp_busy = 1'b0;
    logic [31:0] hold_cpu = '0;
    logic [31:0] hold_dma = '0;
    initial forever begin
        gnt_t g;
        rv_t  r;
        @(posedge clk); #2;
        if (prev_rst) begin
            hold_cpu = '0;
            hold_dma = '0;
        end
        exp_busy = (cyc >= b_lo) && (cyc <= b_hi);
        if (rst_n) begin
            for (int i = exp_rv.size() - 1; i >= 0; i--)
                if (exp_rv[i].cyc >= cyc) exp_rv.delete(i);
            if (b_hi > cyc) b_hi = cyc;
            free_at    = cyc + 1;
            m_last_dma = 1'b1;
        end else if (cyc >= free_at && (bus.cpu_req || bus.dma_req)) begin
            g.cyc   = cyc;
            g.dma   = bus.dma_req && (!bus.cpu_req || !m_last_dma);
            g.we    = g.dma ? bus.dma_we    : bus.cpu_we;
            g.addr  = g.dma ? bus.dma_addr  : bus.cpu_addr;
            g.wdata = g.dma ? bus.dma_wdata : bus.cpu_wdata;
            m_last_dma = g.dma;
            exp_g.push_back(g);
            if (g.we) begin
                ref_mem[g.addr] = g.wdata;
                free_at = cyc + 1;
            end else begin
                r.cyc  = cyc + MEM_LAT;
                r.dma  = g.dma;
                r.data = ref_mem.exists(g.addr) ? ref_mem[g.addr] : dflt(g.addr);
                exp_rv.push_back(r);
                free_at = cyc + MEM_LAT + 1;
                b_lo = cyc + 1;
                b_hi = cyc + MEM_LAT;
            end
        end
        prev_rst = rst_n;
    end

    // Monitor: pops an expectation whenever one falls due, otherwise checks the quiet bus
    initial forever begin
        gnt_t g;
        rv_t  r;
        @(negedge clk);
        cpu_g = bus.cpu_gnt;
        dma_g = bus.dma_gnt;
        if (mon_en) begin
            if (exp_g.size() > 0 && exp_g[0].cyc == cyc) begin
                g = exp_g.pop_front();
                chk("cpu_gnt", bus.cpu_gnt, !g.dma);
                chk("dma_gnt", bus.dma_gnt, g.dma);
                chk("mem_en", bus.mem_en, 1'b1);
                chk("mem_we", bus.mem_we, g.we);
                chk("mem_addr", bus.mem_addr, g.addr);
                if (g.we) chk("mem_wdata", bus.mem_wdata, g.wdata);
            end else begin
                chk("cpu_gnt_quiet", bus.cpu_gnt, 1'b0);
                chk("dma_gnt_quiet", bus.dma_gnt, 1'b0);
                chk("mem_bus_quiet", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 64'd0);
            end
            if (exp_rv.size() > 0 && exp_rv[0].cyc == cyc) begin
                r = exp_rv.pop_front();
                chk("cpu_rvalid", bus.cpu_rvalid, !r.dma);
                chk("dma_rvalid", bus.dma_rvalid, r.dma);
                if (r.dma) hold_dma = r.data;
                else       hold_cpu = r.data;
            end else begin
                chk("cpu_rvalid_quiet", bus.cpu_rvalid, 1'b0);
                chk("dma_rvalid_quiet", bus.dma_rvalid, 1'b0);
            end
            chk("cpu_rdata", bus.cpu_rdata, hold_cpu);
            chk("dma_rdata", bus.dma_rdata, hold_dma);
            chk("busy", bus.busy, exp_busy);
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (n < 500 && (cpu_q.size() > 0 || dma_q.size() > 0 || bus.cpu_req || bus.dma_req
                               || bus.busy || exp_g.size() > 0 || exp_rv.size() > 0));
        if (n >= 500) begin
            n_chk++; n_err++;
            $display("FAIL timeout %s: still active after %0d cycles", tag, n);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        mon_en = 1'b1;

        // Tie of two reads straight after reset
        @(negedge clk);
        push_stim(0, 0, 32'h10, 0, 0);
        push_stim(1, 0, 32'h20, 0, 0);
        wait_idle("tie_reads");

        // Known read data with MEM_LAT=2
        env_mem[32'h100] = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        push_stim(0, 0, 32'h100, 0, 0);
        wait_idle("deadbeef");

        // Continuous writes from both masters
        for (int i = 0; i < 6; i++) begin
            push_stim(0, 1, 32'h200 + 32'(i * 4), 32'hC000_0000 + 32'(i), 0);
            push_stim(1, 1, 32'h300 + 32'(i * 4), 32'hD000_0000 + 32'(i), 0);
        end
        wait_idle("alt_writes");

        // CPU arrives while DMA read is outstanding
        push_stim(1, 0, 32'h300, 0, 0);
        push_stim(0, 0, 32'h204, 0, 1);
        wait_idle("dma_wait");

        // Reset abandons a CPU read, then CPU wins the next tie
        push_stim(0, 0, 32'h208, 0, 0);
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!cpu_g && n < 50);
        if (!cpu_g) begin
            n_chk++; n_err++;
            $display("FAIL timeout cpu_grant_before_reset: no grant in %0d cycles", n);
        end
        pulse_reset();
        @(negedge clk);
        push_stim(0, 0, 32'h20C, 0, 0);
        push_stim(1, 0, 32'h30C, 0, 0);
        wait_idle("reset_in_wait");

        // DMA alone, four writes
        for (int i = 0; i < 4; i++)
            push_stim(1, 1, 32'h400 + 32'(i * 4), $urandom, 0);
        wait_idle("dma_only");

        // Random traffic with occasional resets
        for (int round = 0; round < 40; round++) begin
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                push_stim(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                          int'($urandom_range(0, 3)));
            for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                push_stim(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                          int'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(0, 6)) @(posedge clk);
                pulse_reset();
            end
            wait_idle("random");
        end

        chk("grants_left", 64'(exp_g.size()), 64'd0);
        chk("rvalids_left", 64'(exp_rv.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end
endmodule
